dm_cache_ctrl: RTL
==================

# dm_cache_ctrl

Parametrised direct-mapped write-back cache controller between a byte-wide CPU bus and the `sdramburst` host port. It is the successor of the 32-line, fill-only, hard-wired cache in the BBC2 top level, with these additions:
- line count, burst length and address width are parameters;
- dirty lines are written back (spilled) before refill;
- an explicit flush/invalidate command.

All logic runs on `clk1x`.

## Interface
Parameters:
- `ADDR_W`, 24, CPU/SDRAM byte address width.
- `LINES`, 32, number of cache lines; power of two, ≥2.
- `BURST_LEN`, 8, 16-bit words per line (= per SDRAM burst); power of two, 2..8. Line size is 2·BURST_LEN bytes.

Ports:
- `clk1x` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `cpu_req` in 1: access request; held with `cpu_addr`/`cpu_we`/`cpu_wdata` stable until `cpu_ack`.
- `cpu_we` in 1: 1 = write byte, 0 = read.
- `cpu_addr` in ADDR_W: byte address.
- `cpu_wdata` in 8: write data.
- `cpu_rdata` out 8: read data, valid in the `cpu_ack` cycle.
- `cpu_ack` out 1: one-cycle completion pulse.
- `flush_req` in 1: one-cycle pulse; write back all dirty lines, then invalidate all lines.
- `flush_done` out 1: one-cycle pulse when the flush completes.
- `busy` out 1: high whenever the state is not IDLE.
- `sdram_rd` out 1: one-cycle burst-read request.
- `sdram_wr` out 1: one-cycle burst-write request.
- `sdram_addr` out ADDR_W: line-aligned byte address; low log2(2·BURST_LEN) bits are 0.
- `sdram_ready` in 1: one beat transferred this cycle.
- `sdram_burst_offset` in 3: word index of the current beat.
- `sdram_out` in 16: read data from SDRAM.
- `sdram_in` out 16: write data to SDRAM, combinational: line word [`sdram_burst_offset`] of the spilling line.

## Operation
- Address split, low to high: `off` = log2(2·BURST_LEN) bits, `idx` = log2(LINES) bits, `tag` = the remaining bits.
- Per line: valid bit, dirty bit, tag, and 2·BURST_LEN data bytes.
- Word w holds byte 2w in bits [7:0] and byte 2w+1 in bits [15:8].
- **IDLE**: `flush_req` has priority over `cpu_req` when both are present in the same cycle.
  - On `cpu_req`: latch addr/we/wdata, go to COMPARE.
  - On `flush_req`: set scan index to 0, go to FSCAN.
- **COMPARE**: hit = valid[idx] && tag[idx] == tag.
  - Hit, read: `cpu_rdata` = byte; pulse `cpu_ack`; go to IDLE.
  - Hit, write: write the byte; set dirty[idx]; pulse `cpu_ack`; go to IDLE.
  - Miss, line valid and dirty: go to SPILL.
  - Miss otherwise: go to FILL.
- **SPILL**:
  - On the first cycle, pulse `sdram_wr` with `sdram_addr` = {old tag, idx, 0}.
  - Count `sdram_ready` beats; after BURST_LEN beats, clear dirty[idx].
  - Return to FSCAN if flushing, otherwise go to FILL.
- **FILL**:
  - On the first cycle, pulse `sdram_rd` with `sdram_addr` = {tag, idx, 0}.
  - On each `sdram_ready` beat, write `sdram_out` to word [`sdram_burst_offset`].
  - On the beat with offset == BURST_LEN−1: set valid, clear dirty, store tag, go to COMPARE. The access then completes as a hit.
- **FSCAN**:
  - If line[scan] is valid and dirty, go to SPILL for that line.
  - Otherwise clear valid[scan] and increment scan.
  - After line LINES−1 is handled: pulse `flush_done`, go to IDLE.
  - A line is spilled and then invalidated in the same pass.
- `cpu_req` and `flush_req` are ignored outside IDLE; a lost `flush_req` is the caller's fault, so check `busy`.
- `sdram_ready` outside SPILL/FILL is ignored.

## Timing
- Reset values:
  - `cpu_ack`, `flush_done`, `sdram_rd`, `sdram_wr` = 0.
  - `sdram_addr` = 0; `cpu_rdata` = 0; `busy` = 0.
  - All valid and dirty bits = 0; state = IDLE. Data and tag arrays are not reset.
- Reset mid-burst aborts immediately; later beats are ignored. `sdramburst` shares `reset`.
- Hit latency:
  - `cpu_req` is sampled at edge E0.
  - COMPARE occupies cycle E0→E1.
  - `cpu_ack` is high for exactly one cycle, E1→E2.
- The master must drop or change `cpu_req` in the ack cycle. If `cpu_req` is still high when the block returns to IDLE, it starts a new access.
- Clean-miss latency = 1 (COMPARE) + 1 (`sdram_rd`) + SDRAM latency + BURST_LEN beats + 1 (COMPARE) + ack.
- Dirty-miss latency additionally includes the full spill burst first.
- `sdram_in` must be valid combinationally in every cycle where `sdram_ready` is high during SPILL.
- `sdram_burst_offset` values ≥ BURST_LEN never occur and are don't-care.

## Test plan
- **Reset then cold read**, addr 0x000123, SDRAM returns words 0x0100+w:
  - one `sdram_rd` with `sdram_addr` = 0x000120;
  - `cpu_rdata` = 0x01 (byte 3 = high byte of word 1 = 0x0101);
  - a second read of 0x000122 hits with ack 2 cycles after req.
- **Write hit**: write 0xA5 to 0x000124, read it back → 0xA5. No SDRAM activity.
- **Dirty eviction** (defaults: LINES=32, 16-byte lines): after the write hit, read 0x000324, which has the same idx:
  - `sdram_wr` at 0x000120 precedes `sdram_rd` at 0x000320;
  - spilled word 2 = 0x01A5 in the spill beat with `sdram_burst_offset` = 2.
- **Flush** with 3 dirty lines of 32:
  - exactly 3 `sdram_wr` bursts, then `flush_done`;
  - the next read of any cached address misses (`sdram_rd`).
- **Simultaneous `flush_req` and `cpu_req` in IDLE**: the flush runs first; the CPU access completes after `flush_done`.
- **Reset in the middle of a FILL** (after 3 beats): outputs return to their reset values next cycle; the re-issued access refills the whole line.
- Rerun the above with LINES=4, BURST_LEN=2, ADDR_W=16.

Source files
------------

// File: rtl/dm_cache_ctrl.sv
// rtl/dm_cache_ctrl.sv - direct-mapped write-back cache between a byte-wide CPU bus and the sdramburst host port
module dm_cache_ctrl #(
    parameter int ADDR_W    = 24,
    parameter int LINES     = 32,
    parameter int BURST_LEN = 8
) (
    input  logic              clk1x,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ack,
    input  logic              flush_req,
    output logic              flush_done,
    output logic              busy,
    output logic              sdram_rd,
    output logic              sdram_wr,
    output logic [ADDR_W-1:0] sdram_addr,
    input  logic              sdram_ready,
    input  logic [2:0]        sdram_burst_offset,
    input  logic [15:0]       sdram_out,
    output logic [15:0]       sdram_in
);
    localparam int OFF_W = $clog2(2 * BURST_LEN);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
    localparam int WRD_W = $clog2(BURST_LEN);
    localparam int BYTES = LINES * 2 * BURST_LEN;

    localparam logic [OFF_W-1:0] OFF_ZERO  = '0;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LINES - 1);
    localparam logic [WRD_W-1:0] LAST_WORD = WRD_W'(BURST_LEN - 1);
    localparam logic [2:0]       LAST_OFF  = 3'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMPARE,
        S_SPILL,
        S_FILL,
        S_FSCAN
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [7:0]          wdata_q, wdata_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic [LINES-1:0]    dirty_q, dirty_d;
    logic [IDX_W-1:0]    scan_q, scan_d;
    logic [IDX_W-1:0]    line_q, line_d;
    logic [WRD_W-1:0]    cnt_q, cnt_d;
    logic                flushing_q, flushing_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic [7:0]          cpu_rdata_q, cpu_rdata_d;
    logic                flush_done_q, flush_done_d;
    logic                sdram_rd_q, sdram_rd_d;
    logic                sdram_wr_q, sdram_wr_d;
    logic [ADDR_W-1:0]   sdram_addr_q, sdram_addr_d;

    logic [TAG_W-1:0]    tag_mem [LINES];
    logic [7:0]          data_mem [BYTES];

    logic                byte_we, fill_we, tag_we;
    logic [OFF_W-1:0]    req_off;
    logic [IDX_W-1:0]    req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic                hit;
    logic [IDX_W+WRD_W-1:0] fill_base, spill_base;

    assign req_off    = addr_q[OFF_W-1:0];
    assign req_idx    = addr_q[OFF_W +: IDX_W];
    assign req_tag    = addr_q[ADDR_W-1 -: TAG_W];
    assign hit        = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign fill_base  = {req_idx, sdram_burst_offset[WRD_W-1:0]};
    assign spill_base = {line_q, sdram_burst_offset[WRD_W-1:0]};

    // Word w of a line is byte 2w (low) and byte 2w+1 (high).
    assign sdram_in = {data_mem[{spill_base, 1'b1}], data_mem[{spill_base, 1'b0}]};

    assign cpu_rdata  = cpu_rdata_q;
    assign cpu_ack    = cpu_ack_q;
    assign flush_done = flush_done_q;
    assign sdram_rd   = sdram_rd_q;
    assign sdram_wr   = sdram_wr_q;
    assign sdram_addr = sdram_addr_q;
    assign busy       = (state_q != S_IDLE);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        scan_d       = scan_q;
        line_d       = line_q;
        cnt_d        = cnt_q;
        flushing_d   = flushing_q;
        cpu_ack_d    = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        flush_done_d = 1'b0;
        sdram_rd_d   = 1'b0;
        sdram_wr_d   = 1'b0;
        sdram_addr_d = sdram_addr_q;
        byte_we      = 1'b0;
        fill_we      = 1'b0;
        tag_we       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (flush_req) begin
                    scan_d     = '0;
                    flushing_d = 1'b1;
                    state_d    = S_FSCAN;
                end else if (cpu_req) begin
                    addr_d  = cpu_addr;
                    we_d    = cpu_we;
                    wdata_d = cpu_wdata;
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (hit) begin
                    cpu_ack_d = 1'b1;
                    state_d   = S_IDLE;
                    if (we_q) begin
                        byte_we          = 1'b1;
                        dirty_d[req_idx] = 1'b1;
                    end else begin
                        cpu_rdata_d = data_mem[{req_idx, req_off}];
                    end
                end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
                    line_d       = req_idx;
                    cnt_d        = '0;
                    sdram_wr_d   = 1'b1;
                    sdram_addr_d = {tag_mem[req_idx], req_idx, OFF_ZERO};
                    state_d      = S_SPILL;
                end else begin
                    sdram_rd_d   = 1'b1;
                    sdram_addr_d = {req_tag, req_idx, OFF_ZERO};
                    state_d      = S_FILL;
                end
            end
            S_SPILL: begin
                if (sdram_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        dirty_d[line_q] = 1'b0;
                        if (flushing_q) begin
                            state_d = S_FSCAN;
                        end else begin
                            sdram_rd_d   = 1'b1;
                            sdram_addr_d = {req_tag, req_idx, OFF_ZERO};
                            state_d      = S_FILL;
                        end
                    end
                end
            end
            S_FILL: begin
                if (sdram_ready) begin
                    fill_we = 1'b1;
                    if (sdram_burst_offset == LAST_OFF) begin
                        valid_d[req_idx] = 1'b1;
                        dirty_d[req_idx] = 1'b0;
                        tag_we           = 1'b1;
                        state_d          = S_COMPARE;
                    end
                end
            end
            S_FSCAN: begin
                // A dirty line is spilled first; the scan then revisits it, now clean, and invalidates it.
                if (valid_q[scan_q] && dirty_q[scan_q]) begin
                    line_d       = scan_q;
                    cnt_d        = '0;
                    sdram_wr_d   = 1'b1;
                    sdram_addr_d = {tag_mem[scan_q], scan_q, OFF_ZERO};
                    state_d      = S_SPILL;
                end else begin
                    valid_d[scan_q] = 1'b0;
                    if (scan_q == LAST_IDX) begin
                        flush_done_d = 1'b1;
                        flushing_d   = 1'b0;
                        state_d      = S_IDLE;
                    end else begin
                        scan_d = scan_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk1x) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            valid_q      <= '0;
            dirty_q      <= '0;
            scan_q       <= '0;
            line_q       <= '0;
            cnt_q        <= '0;
            flushing_q   <= 1'b0;
            cpu_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            flush_done_q <= 1'b0;
            sdram_rd_q   <= 1'b0;
            sdram_wr_q   <= 1'b0;
            sdram_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            scan_q       <= scan_d;
            line_q       <= line_d;
            cnt_q        <= cnt_d;
            flushing_q   <= flushing_d;
            cpu_ack_q    <= cpu_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
            flush_done_q <= flush_done_d;
            sdram_rd_q   <= sdram_rd_d;
            sdram_wr_q   <= sdram_wr_d;
            sdram_addr_q <= sdram_addr_d;
        end
    end

    // Tag and data storage carry no reset; the valid bits qualify them.
    always_ff @(posedge clk1x) begin
        if (byte_we) begin
            data_mem[{req_idx, req_off}] <= wdata_q;
        end
        if (fill_we) begin
            data_mem[{fill_base, 1'b0}] <= sdram_out[7:0];
            data_mem[{fill_base, 1'b1}] <= sdram_out[15:8];
        end
        if (tag_we) begin
            tag_mem[req_idx] <= req_tag;
        end
    end
endmodule
